alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares the single 8-bit ALU between two requesters, requester 0 (execute stage) and requester 1 (auxiliary unit, e.g. loop/address counter). Each cycle it grants at most one request, registers that request's operands and function code into an issue stage that drives the ALU, and registers the ALU result and flags one cycle later. It also owns the condition-code register (CCR), updating only the flags that the issued function defines.

## Interface
Parameters:
- none

Ports (clock and reset first):
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- stall  in  1  pipeline freeze; blocks grants and holds all stages
- req0 / req1  in  1  request valid, requester 0 / 1
- a0, b0 / a1, b1  in  8 each  operands (signed), requester 0 / 1
- fun0 / fun1  in  6  ALU function code, requester 0 / 1
- gnt0 / gnt1  out  1  combinational grant; the request is consumed this cycle
- alu_a, alu_b  out  8  registered operands to ALU
- alu_fun  out  6  registered function code to ALU; 0 when issue stage is empty
- alu_res  in  8  ALU result (combinational from alu_a/alu_b/alu_fun)
- alu_flags  in  4  ALU flags {overflow, cout, neg, zero}
- rsp_valid  out  1  one-cycle result strobe
- rsp_id  out  1  requester that owns rsp_data
- rsp_data  out  8  captured ALU result
- ccr  out  4  condition codes {V, C, N, Z}
- busy  out  1  issue stage holds a valid op

## Operation
- Arbitration (stall=0): one request -> granted. Both -> round-robin pointer `rr` picks; after any grant `rr` points to the other requester. `rr` resets to 0. Never both gnt high.
- stall=1: gnt0=gnt1=0; issue stage, response stage, `rr` and ccr hold; rsp_valid=0.
- Issue stage: on grant, captures a, b, fun, id; issue_valid=1. No grant -> issue_valid=0, alu_fun=0, alu_a/alu_b hold.
- Response stage: if issue_valid and stall=0, captures alu_res into rsp_data, id into rsp_id, pulses rsp_valid. Otherwise rsp_valid=0, rsp_data/rsp_id hold.
- CCR update at response capture, per fun masks:
  - 2 (ADD), 3 (SUB): V, C, N, Z all from alu_flags.
  - 5, 14, 15, 16, 17 (OR, NOT, NEG, INC, DEC): N, Z only.
  - 6, 7, 8, 9 (RLC, RRC, SETC, CLRC): C only.
  - any other code: no update.
- busy = issue_valid.
- Reset (asynchronous, any time): all outputs and state to 0, including ccr, rsp_*, alu_*, `rr`. In-flight ops are dropped with no rsp_valid. Requests present at reset release are arbitrated in the first clocked cycle.

## Timing
- gnt is combinational from req/stall/rr in the same cycle.
- Request granted in cycle N -> alu_* valid in N+1 -> rsp_valid, rsp_data, ccr update visible in N+2. Latency 2 cycles, throughput 1 op/cycle.
- Each stall cycle adds exactly one cycle to every in-flight op; ordering is preserved.
- Back-to-back ops: ccr after cycle N+2 reflects op N; op N+1 sees it one cycle later. No forwarding.

## Configuration
- ALU_ARB_FIXED_PRIO_EN defined: requester 0 always wins when both request; `rr` is not implemented; requester 1 is served only when req0=0.
- Undefined (default): round-robin as above.

## Test plan
- Reset, req0 ADD a0=0x7F b0=0x01 at N -> gnt0=1 at N; rsp_valid=1, rsp_id=0, rsp_data=0x80 at N+2; ccr=4'b1010.
- req0 and req1 held high 4 cycles, all fun=16 (INC) -> grants 0,1,0,1; responses with ids 0,1,0,1 at N+2..N+5. With ALU_ARB_FIXED_PRIO_EN: grants 0,0,0,0.
- SETC (fun=8) then OR 0x00|0x00 back-to-back -> ccr 4'b0100, then 4'b0101 (C preserved, Z set).
- req1 SUB 0x00-0x01 granted at N, stall=1 during N+1 -> no rsp at N+2; rsp_valid at N+3, rsp_data=0xFF, ccr C=1, N=1; gnt=0 during stall.
- Grant at N, reset asserted in N+1 -> rsp_valid never pulses, ccr=0, busy=0; after release, req0 fun=20 passes b0=0x33 -> rsp_data=0x33, ccr unchanged.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// Bus bundle between the two ALU requesters, the shared ALU and alu_arbiter.
// The master side drives requests and ALU results; the slave side is the arbiter.
interface alu_arbiter_if;
    logic       stall;
    logic       req0;
    logic       req1;
    logic [7:0] a0;
    logic [7:0] b0;
    logic [7:0] a1;
    logic [7:0] b1;
    logic [5:0] fun0;
    logic [5:0] fun1;
    logic       gnt0;
    logic       gnt1;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [5:0] alu_fun;
    logic [7:0] alu_res;
    logic [3:0] alu_flags;
    logic       rsp_valid;
    logic       rsp_id;
    logic [7:0] rsp_data;
    logic [3:0] ccr;
    logic       busy;

    modport master (
        output stall, req0, req1, a0, b0, a1, b1, fun0, fun1, alu_res, alu_flags,
        input  gnt0, gnt1, alu_a, alu_b, alu_fun, rsp_valid, rsp_id, rsp_data, ccr, busy
    );

    modport slave (
        input  stall, req0, req1, a0, b0, a1, b1, fun0, fun1, alu_res, alu_flags,
        output gnt0, gnt1, alu_a, alu_b, alu_fun, rsp_valid, rsp_id, rsp_data, ccr, busy
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester arbiter for the shared 8-bit ALU with issue/response stages and CCR.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins); default is round-robin.
module alu_arbiter (
    input logic         clk,
    input logic         reset,
    alu_arbiter_if.slave bus
);

    logic       issue_valid;
    logic       issue_id;
    logic [7:0] issue_a;
    logic [7:0] issue_b;
    logic [5:0] issue_fun;
    logic       rsp_valid_q;
    logic       rsp_id_q;
    logic [7:0] rsp_data_q;
    logic [3:0] ccr_q;
    logic [3:0] flag_mask;
    logic       gnt0;
    logic       gnt1;
    logic       any_gnt;

`ifdef ALU_ARB_FIXED_PRIO_EN
    always_comb begin
        gnt0 = !bus.stall && bus.req0;
        gnt1 = !bus.stall && bus.req1 && !bus.req0;
    end
`else
    // rr names the requester that wins the next contended cycle
    logic rr;

    always_comb begin
        gnt0 = !bus.stall && bus.req0 && (!bus.req1 || !rr);
        gnt1 = !bus.stall && bus.req1 && (!bus.req0 || rr);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr <= 1'b0;
        end else if (gnt0) begin
            rr <= 1'b1;
        end else if (gnt1) begin
            rr <= 1'b0;
        end
    end
`endif

    assign any_gnt = gnt0 || gnt1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            issue_valid <= 1'b0;
            issue_id    <= 1'b0;
            issue_a     <= '0;
            issue_b     <= '0;
            issue_fun   <= '0;
        end else if (!bus.stall) begin
            if (any_gnt) begin
                issue_valid <= 1'b1;
                issue_id    <= gnt1;
                issue_a     <= gnt1 ? bus.a1   : bus.a0;
                issue_b     <= gnt1 ? bus.b1   : bus.b0;
                issue_fun   <= gnt1 ? bus.fun1 : bus.fun0;
            end else begin
                issue_valid <= 1'b0;
                issue_fun   <= '0;
            end
        end
    end

    // CCR bits {V,C,N,Z} each function is allowed to overwrite
    always_comb begin
        flag_mask = 4'b0000;
        case (issue_fun)
            6'd2, 6'd3:                         flag_mask = 4'b1111;
            6'd5, 6'd14, 6'd15, 6'd16, 6'd17:   flag_mask = 4'b0011;
            6'd6, 6'd7, 6'd8, 6'd9:             flag_mask = 4'b0100;
            default:                            flag_mask = 4'b0000;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_data_q  <= '0;
            ccr_q       <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            if (!bus.stall && issue_valid) begin
                rsp_valid_q <= 1'b1;
                rsp_id_q    <= issue_id;
                rsp_data_q  <= bus.alu_res;
                ccr_q       <= (ccr_q & ~flag_mask) | (bus.alu_flags & flag_mask);
            end
        end
    end

    assign bus.gnt0      = gnt0;
    assign bus.gnt1      = gnt1;
    assign bus.alu_a     = issue_a;
    assign bus.alu_b     = issue_b;
    assign bus.alu_fun   = issue_fun;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.ccr       = ccr_q;
    assign bus.busy      = issue_valid;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus random traffic
// against a queue-based model of grants, latency and condition codes.
module tb_alu_arbiter;

    logic clk;
    logic reset;

    alu_arbiter_if ifc ();

    alu_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned errors = 0;
    int unsigned checks = 0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Stand-in ALU: {flags, result}, flags = {overflow, cout, neg, zero}
    function automatic logic [11:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                              input logic [5:0] fun);
        logic [8:0] s;
        logic [7:0] r;
        logic       c;
        logic       v;
        s = '0; c = 1'b0; v = 1'b0;
        case (fun)
            6'd2:  begin s = {1'b0, a} + {1'b0, b}; r = s[7:0]; c = s[8];
                         v = (a[7] == b[7]) && (r[7] != a[7]); end
            6'd3:  begin s = {1'b0, a} - {1'b0, b}; r = s[7:0]; c = s[8];
                         v = (a[7] != b[7]) && (r[7] != a[7]); end
            6'd5:  r = a | b;
            6'd6:  begin r = {a[6:0], a[7]}; c = a[7]; end
            6'd7:  begin r = {a[0], a[7:1]}; c = a[0]; end
            6'd8:  begin r = a; c = 1'b1; end
            6'd9:  begin r = a; c = 1'b0; end
            6'd14: r = ~a;
            6'd15: r = 8'd0 - a;
            6'd16: r = a + 8'd1;
            6'd17: r = a - 8'd1;
            default: r = b;
        endcase
        return {v, c, r[7], (r == 8'd0), r};
    endfunction

    always_comb {ifc.alu_flags, ifc.alu_res} = alu_model(ifc.alu_a, ifc.alu_b, ifc.alu_fun);

    function automatic logic [3:0] ccr_mask(input logic [5:0] fun);
        if (fun inside {6'd2, 6'd3})                       return 4'b1111;
        if (fun inside {6'd5, 6'd14, 6'd15, 6'd16, 6'd17}) return 4'b0011;
        if (fun inside {6'd6, 6'd7, 6'd8, 6'd9})           return 4'b0100;
        return 4'b0000;
    endfunction

    typedef struct {
        int unsigned due;
        logic        id;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [5:0]  fun;
        logic [7:0]  data;
        logic [3:0]  flags;
    } op_t;

    op_t         q[$];
    int unsigned tick = 0;   // counts non-stalled clock edges
    logic        next_pri;
    logic        m_valid;
    logic        m_id;
    logic [7:0]  m_data;
    logic [7:0]  m_a;
    logic [7:0]  m_b;
    logic [3:0]  m_ccr;
    logic        obs_g0;
    logic        obs_g1;

    logic       r0, r1;
    logic [7:0] xa0, xb0, xa1, xb1;
    logic [5:0] f0, f1;

    task automatic model_reset();
        q.delete();
        next_pri = 1'b0;
        m_valid = 1'b0; m_id = 1'b0; m_data = '0;
        m_a = '0; m_b = '0; m_ccr = '0;
    endtask

    task automatic idle_inputs();
        r0 = 1'b0; r1 = 1'b0;
        xa0 = '0; xb0 = '0; xa1 = '0; xb1 = '0; f0 = '0; f1 = '0;
    endtask

    // One clock cycle: called at a falling edge, returns at the next falling edge.
    task automatic step(input logic st);
        logic eg0, eg1;
        op_t  o;
        ifc.stall = st;
        ifc.req0 = r0; ifc.a0 = xa0; ifc.b0 = xb0; ifc.fun0 = f0;
        ifc.req1 = r1; ifc.a1 = xa1; ifc.b1 = xb1; ifc.fun1 = f1;
        #1;
        eg0 = 1'b0; eg1 = 1'b0;
        if (!st) begin
            if (r0 && r1) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
                eg0 = 1'b1;
`else
                eg0 = !next_pri;
                eg1 = next_pri;
`endif
            end else begin
                eg0 = r0;
                eg1 = r1;
            end
        end
        obs_g0 = ifc.gnt0;
        obs_g1 = ifc.gnt1;
        check("gnt0", 16'(ifc.gnt0), 16'(eg0));
        check("gnt1", 16'(ifc.gnt1), 16'(eg1));
        @(posedge clk);
        m_valid = 1'b0;
        if (!st) begin
            tick++;
            if (q.size() != 0 && q[0].due == tick) begin
                o = q.pop_front();
                m_valid = 1'b1;
                m_id    = o.id;
                m_data  = o.data;
                m_ccr   = (m_ccr & ~ccr_mask(o.fun)) | (o.flags & ccr_mask(o.fun));
            end
            if (eg0 || eg1) begin
                o.due = tick + 1;
                o.id  = eg1;
                o.a   = eg1 ? xa1 : xa0;
                o.b   = eg1 ? xb1 : xb0;
                o.fun = eg1 ? f1  : f0;
                {o.flags, o.data} = alu_model(o.a, o.b, o.fun);
                q.push_back(o);
                m_a = o.a;
                m_b = o.b;
                next_pri = !eg1;
            end
        end
        @(negedge clk);
        check("rsp_valid", 16'(ifc.rsp_valid), 16'(m_valid));
        check("rsp_id",    16'(ifc.rsp_id),    16'(m_id));
        check("rsp_data",  16'(ifc.rsp_data),  16'(m_data));
        check("ccr",       16'(ifc.ccr),       16'(m_ccr));
        check("busy",      16'(ifc.busy),      16'(q.size() != 0));
        check("alu_fun",   16'(ifc.alu_fun),   16'((q.size() != 0) ? q[0].fun : 6'd0));
        check("alu_a",     16'(ifc.alu_a),     16'(m_a));
        check("alu_b",     16'(ifc.alu_b),     16'(m_b));
    endtask

    task automatic drain();
        idle_inputs();
        repeat (3) step(1'b0);
    endtask

    localparam logic [5:0] FUNS [14] = '{6'd2, 6'd3, 6'd5, 6'd6, 6'd7, 6'd8, 6'd9,
                                         6'd14, 6'd15, 6'd16, 6'd17, 6'd20, 6'd0, 6'd33};

    initial begin
        logic [3:0] gpat0;
        logic [3:0] gpat1;
        logic [3:0] exp_pat0;
        logic [3:0] exp_pat1;

        reset = 1'b0;
        idle_inputs();
        ifc.stall = 1'b0;
        ifc.req0 = 1'b0; ifc.req1 = 1'b0;
        ifc.a0 = '0; ifc.b0 = '0; ifc.a1 = '0; ifc.b1 = '0; ifc.fun0 = '0; ifc.fun1 = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_busy",  16'(ifc.busy),      16'h0);
        check("rst_ccr",   16'(ifc.ccr),       16'h0);
        check("rst_rsp_v", 16'(ifc.rsp_valid), 16'h0);
        check("rst_fun",   16'(ifc.alu_fun),   16'h0);
        reset = 1'b1;

        // SETC then OR 0|0: C set alone, then Z set with C preserved
        idle_inputs(); r0 = 1'b1; f0 = 6'd8; xa0 = 8'h5A;
        step(1'b0);
        idle_inputs(); r0 = 1'b1; f0 = 6'd5;
        step(1'b0);
        check("setc_ccr", 16'(ifc.ccr), 16'h4);
        idle_inputs();
        step(1'b0);
        check("or_ccr", 16'(ifc.ccr), 16'h5);
        drain();

        // ADD 0x7F + 0x01
        idle_inputs(); r0 = 1'b1; f0 = 6'd2; xa0 = 8'h7F; xb0 = 8'h01;
        step(1'b0);
        check("add_gnt0", 16'(obs_g0), 16'h1);
        idle_inputs();
        step(1'b0);
        check("add_rsp_v",  16'(ifc.rsp_valid), 16'h1);
        check("add_rsp_id", 16'(ifc.rsp_id),    16'h0);
        check("add_data",   16'(ifc.rsp_data),  16'h80);
        check("add_ccr",    16'(ifc.ccr),       16'hA);
        drain();

        // SUB 0x00 - 0x01 from requester 1 with one stall cycle
        idle_inputs(); r1 = 1'b1; f1 = 6'd3; xa1 = 8'h00; xb1 = 8'h01;
        step(1'b0);
        idle_inputs(); r0 = 1'b1; f0 = 6'd16;
        step(1'b1);
        check("stall_gnt0", 16'(obs_g0),        16'h0);
        check("stall_rsp",  16'(ifc.rsp_valid), 16'h0);
        idle_inputs();
        step(1'b0);
        check("sub_rsp_v", 16'(ifc.rsp_valid), 16'h1);
        check("sub_data",  16'(ifc.rsp_data),  16'hFF);
        check("sub_c",     16'(ifc.ccr[2]),    16'h1);
        check("sub_n",     16'(ifc.ccr[1]),    16'h1);
        drain();

        // Both requesters held for four cycles
        gpat0 = '0; gpat1 = '0;
        for (int i = 0; i < 4; i++) begin
            idle_inputs(); r0 = 1'b1; r1 = 1'b1; f0 = 6'd16; f1 = 6'd16;
            xa0 = 8'(i); xa1 = 8'(8'h40 + i);
            step(1'b0);
            gpat0[i] = obs_g0;
            gpat1[i] = obs_g1;
        end
`ifdef ALU_ARB_FIXED_PRIO_EN
        exp_pat0 = 4'b1111; exp_pat1 = 4'b0000;
`else
        exp_pat0 = 4'b0101; exp_pat1 = 4'b1010;
`endif
        check("both_g0", 16'(gpat0), 16'(exp_pat0));
        check("both_g1", 16'(gpat1), 16'(exp_pat1));
        drain();

        // Reset while an op is in the issue stage
        idle_inputs(); r0 = 1'b1; f0 = 6'd2; xa0 = 8'h01; xb0 = 8'h01;
        step(1'b0);
        idle_inputs();
        ifc.req0 = 1'b0; ifc.req1 = 1'b0;
        reset = 1'b0;
        @(posedge clk);
        #2;
        check("mid_rst_busy", 16'(ifc.busy),      16'h0);
        check("mid_rst_ccr",  16'(ifc.ccr),       16'h0);
        check("mid_rst_rsp",  16'(ifc.rsp_valid), 16'h0);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        step(1'b0);
        step(1'b0);
        idle_inputs(); r0 = 1'b1; f0 = 6'd20; xa0 = 8'hC3; xb0 = 8'h33;
        step(1'b0);
        idle_inputs();
        step(1'b0);
        check("pass_data", 16'(ifc.rsp_data), 16'h33);
        check("pass_ccr",  16'(ifc.ccr),      16'h0);
        drain();

        // Random traffic with stalls
        for (int i = 0; i < 500; i++) begin
            r0  = ($urandom_range(0, 99) < 60);
            r1  = ($urandom_range(0, 99) < 60);
            xa0 = 8'($urandom); xb0 = 8'($urandom);
            xa1 = 8'($urandom); xb1 = 8'($urandom);
            f0  = FUNS[$urandom_range(0, 13)];
            f1  = FUNS[$urandom_range(0, 13)];
            step($urandom_range(0, 99) < 15);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
